// File: rtl/main_alu_pkg.sv
// Shared constants for the registered 8-bit ALU.
// Holds the state encodings, operation select indices and datapath width.
package main_alu_pkg;

    localparam int W   = 8;
    localparam int OPS = 6;

    localparam logic [1:0] ST_RESET   = 2'b00;
    localparam logic [1:0] ST_LOAD    = 2'b01;
    localparam logic [1:0] ST_PERSIST = 2'b10;

    localparam int OP_ADD = 0;
    localparam int OP_SUB = 1;
    localparam int OP_AND = 2;
    localparam int OP_OR  = 3;
    localparam int OP_XOR = 4;
    localparam int OP_NOT = 5;

endpackage

// File: rtl/main_alu_core.sv
// Combinational ALU: (num1, num2, out_sel) -> alu_result.
// Ports: num1/num2 operands, out_sel one-hot op select, alu_result.
module main_alu_core
    import main_alu_pkg::*;
(
    input  logic [W-1:0]   num1,
    input  logic [W-1:0]   num2,
    input  logic [OPS-1:0] out_sel,
    output logic [W-1:0]   alu_result
);

    // Lowest set select bit wins; an all-zero or unknown
    // select matches no branch and yields zero.
    always_comb begin
        alu_result = '0;
        case (1'b1)
            out_sel[OP_ADD]: alu_result = num1 + num2;
            out_sel[OP_SUB]: alu_result = num1 - num2;
            out_sel[OP_AND]: alu_result = num1 & num2;
            out_sel[OP_OR]:  alu_result = num1 | num2;
            out_sel[OP_XOR]: alu_result = num1 ^ num2;
            out_sel[OP_NOT]: alu_result = ~num1;
            default:         alu_result = '0;
        endcase
    end

endmodule

// File: rtl/main_alu.sv
// Registered ALU with a RESET/LOAD/PERSIST control FSM.
// Ports: clk, rst_n, in_sel, num1, num2, out_sel, out, currState, nextState.
module main_alu
    import main_alu_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    input  logic [2:0]     in_sel,
    input  logic [W-1:0]   num1,
    input  logic [W-1:0]   num2,
    input  logic [OPS-1:0] out_sel,
    output logic [W-1:0]   out,
    output logic [1:0]     currState,
    output logic [1:0]     nextState
);

    logic [W-1:0] alu_result;
    logic [W-1:0] out_d;

    main_alu_core u_core (
        .num1       (num1),
        .num2       (num2),
        .out_sel    (out_sel),
        .alu_result (alu_result)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            currState <= ST_RESET;
        end else begin
            currState <= nextState;
        end
    end

    // Reset request outranks load, load outranks persist.
    // The unused 2'b11 encoding recovers to RESET.
    always_comb begin
        nextState = ST_PERSIST;
        if (currState == 2'b11) begin
            nextState = ST_RESET;
        end else if (in_sel[0]) begin
            nextState = ST_RESET;
        end else if (in_sel[1]) begin
            nextState = ST_LOAD;
        end else begin
            nextState = ST_PERSIST;
        end
    end

    // The result register follows the state being entered,
    // so a request lands on out after the same edge.
    always_comb begin
        out_d = out;
        case (nextState)
            ST_RESET:   out_d = '0;
            ST_LOAD:    out_d = alu_result;
            ST_PERSIST: out_d = out;
            default:    out_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            out <= out_d;
        end
    end

endmodule

// File: tb/tb_main_alu.sv
// Directed testbench for main_alu.
// Each task drives one scenario and checks against hand-computed values.
module tb_main_alu;

    logic       clk;
    logic       rst_n;
    logic [2:0] in_sel;
    logic [7:0] num1;
    logic [7:0] num2;
    logic [5:0] out_sel;
    logic [7:0] out;
    logic [1:0] currState;
    logic [1:0] nextState;

    int errors;
    int checks;

    main_alu dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_sel    (in_sel),
        .num1      (num1),
        .num2      (num2),
        .out_sel   (out_sel),
        .out       (out),
        .currState (currState),
        .nextState (nextState)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] s, input logic [7:0] a,
                         input logic [7:0] b, input logic [5:0] op);
        in_sel  = s;
        num1    = a;
        num2    = b;
        out_sel = op;
    endtask

    task automatic chk_out(input string name, input logic [7:0] exp);
        checks++;
        if (out !== exp) begin
            errors++;
            $display("FAIL %s: out=%h expected=%h", name, out, exp);
        end
    endtask

    task automatic chk_cs(input string name, input logic [1:0] exp);
        checks++;
        if (currState !== exp) begin
            errors++;
            $display("FAIL %s: currState=%b expected=%b", name, currState, exp);
        end
    endtask

    task automatic chk_ns(input string name, input logic [1:0] exp);
        checks++;
        if (nextState !== exp) begin
            errors++;
            $display("FAIL %s: nextState=%b expected=%b", name, nextState, exp);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(3'b010, 8'h57, 8'h1A, 6'b000001);
        #3;
        chk_out("reset_out", 8'h00);
        chk_cs("reset_cs", 2'b00);
        step();
        chk_out("reset_hold_out", 8'h00);
        chk_cs("reset_hold_cs", 2'b00);
        chk_ns("reset_ns_comb", 2'b01);
        @(negedge clk);
        rst_n = 1'b1;
        drive(3'b001, 8'h57, 8'h1A, 6'b000001);
        step();
        chk_out("rstreq_out", 8'h00);
        chk_cs("rstreq_cs", 2'b00);
    endtask

    task automatic test_load_add();
        drive(3'b010, 8'h57, 8'h1A, 6'b000001);
        #1;
        chk_ns("load_ns", 2'b01);
        step();
        chk_out("load_add", 8'h71);
        chk_cs("load_cs", 2'b01);
    endtask

    task automatic test_ops();
        logic [5:0] sel [5];
        logic [7:0] exp [5];
        sel[0] = 6'b000010; exp[0] = 8'h3D;
        sel[1] = 6'b000100; exp[1] = 8'h12;
        sel[2] = 6'b001000; exp[2] = 8'h5F;
        sel[3] = 6'b010000; exp[3] = 8'h4D;
        sel[4] = 6'b100000; exp[4] = 8'hA8;
        for (int i = 0; i < 5; i++) begin
            drive(3'b010, 8'h57, 8'h1A, sel[i]);
            step();
            chk_out($sformatf("op_%0d", i + 1), exp[i]);
        end
        chk_cs("ops_cs", 2'b01);
    endtask

    task automatic test_persist();
        drive(3'b010, 8'h57, 8'h1A, 6'b000001);
        step();
        chk_out("persist_pre", 8'h71);
        drive(3'b000, 8'h00, 8'h01, 6'b000001);
        #1;
        chk_ns("persist_ns", 2'b10);
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out($sformatf("persist_hold_%0d", i), 8'h71);
        end
        chk_cs("persist_cs", 2'b10);
        drive(3'b100, 8'hFF, 8'hFF, 6'b000001);
        step();
        chk_out("persist_bit2", 8'h71);
    endtask

    task automatic test_wrap();
        drive(3'b010, 8'hFF, 8'h01, 6'b000001);
        step();
        chk_out("wrap_add", 8'h00);
        drive(3'b010, 8'h00, 8'h01, 6'b000010);
        step();
        chk_out("wrap_sub", 8'hFF);
        drive(3'b010, 8'h57, 8'h1A, 6'b000000);
        step();
        chk_out("sel_zero", 8'h00);
        drive(3'b010, 8'h57, 8'h1A, 6'b000011);
        step();
        chk_out("sel_multi", 8'h71);
        drive(3'b010, 8'h57, 8'h1A, 6'b110000);
        step();
        chk_out("sel_multi_hi", 8'h4D);
    endtask

    task automatic test_reset_wins();
        drive(3'b010, 8'h57, 8'h1A, 6'b000001);
        step();
        chk_out("rw_pre", 8'h71);
        drive(3'b111, 8'h57, 8'h1A, 6'b000001);
        #1;
        chk_ns("rw_ns", 2'b00);
        step();
        chk_out("rw_out", 8'h00);
        chk_cs("rw_cs", 2'b00);
    endtask

    task automatic test_async_reset();
        drive(3'b010, 8'h57, 8'h1A, 6'b000001);
        step();
        chk_out("async_pre", 8'h71);
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_out", 8'h00);
        chk_cs("async_cs", 2'b00);
        chk_ns("async_ns", 2'b01);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk_out("async_reload", 8'h71);
        chk_cs("async_reload_cs", 2'b01);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst_n  = 1'b0;
        drive(3'b000, 8'h00, 8'h00, 6'b000000);
        test_reset();
        test_load_add();
        test_ops();
        test_persist();
        test_wrap();
        test_reset_wins();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
